// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, rounding-mode codes and special encodings.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

endpackage

// File: rtl/fpu_lzc28.sv
// Combinational leading-zero counter for the 28-bit raw fraction; an all-zero input yields 28.
module fpu_lzc28 (
  input  logic [27:0] a,
  output logic [4:0]  cnt
);

  // Later (higher) set bits overwrite earlier ones, leaving the count for the leading one.
  always_comb begin
    cnt = 5'd28;
    for (int unsigned i = 0; i < 28; i++) begin
      if (a[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fadd_norm_round.sv
// FP adder final stage: N1 normalizes the raw sum, N2 rounds and packs an IEEE-754 single.
module fadd_norm_round #(
  parameter int unsigned EXP_W = fpu_pkg::EXP_W,
  parameter int unsigned MAN_W = fpu_pkg::MAN_W
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               e,
  input  logic               in_valid,
  input  logic [1:0]         n_rm,
  input  logic               n_is_inf_nan,
  input  logic [MAN_W-1:0]   n_inf_nan_frac,
  input  logic               n_sign,
  input  logic [EXP_W-1:0]   n_exp,
  input  logic [MAN_W+4:0]   n_frac,
  output logic [EXP_W+MAN_W:0] s,
  output logic               s_valid,
  output logic               s_ovf,
  output logic               s_inexact
);
  import fpu_pkg::RM_RNE;
  import fpu_pkg::RM_RZ;
  import fpu_pkg::RM_RUP;
  import fpu_pkg::RM_RDN;

  localparam int unsigned FW = MAN_W + 5;
  localparam logic [EXP_W:0] EXP_LIMIT = {1'b0, {EXP_W{1'b1}}};

  // ---------------- N1: normalize ----------------
  logic [4:0]       lzc;
  logic [4:0]       lz27;
  logic [EXP_W-1:0] exp_m1;
  logic [EXP_W-1:0] shamt;
  logic [FW-2:0]    nf;
  logic [EXP_W:0]   exp_n;
  logic             zero_n;

  fpu_lzc28 u_lzc (
    .a   (n_frac),
    .cnt (lzc)
  );

  // With bit27 clear, leading zeros of frac[26:0] are one less than the 28-bit count.
  always_comb begin
    nf     = n_frac[FW-2:0];
    exp_n  = {1'b0, n_exp};
    zero_n = 1'b0;
    shamt  = '0;
    lz27   = lzc - 5'd1;
    exp_m1 = n_exp - {{(EXP_W-1){1'b0}}, 1'b1};
    if (n_frac[FW-1]) begin
      nf    = {n_frac[FW-1:2], n_frac[1] | n_frac[0]};
      exp_n = {1'b0, n_exp} + {{EXP_W{1'b0}}, 1'b1};
    end else if (n_frac == '0) begin
      zero_n = 1'b1;
      nf     = '0;
      exp_n  = '0;
    end else begin
      if (n_exp != '0) begin
        if ({{(EXP_W-5){1'b0}}, lz27} < exp_m1) shamt = {{(EXP_W-5){1'b0}}, lz27};
        else                                    shamt = exp_m1;
      end
      nf    = n_frac[FW-2:0] << shamt;
      exp_n = {1'b0, n_exp - shamt};
      if (!nf[FW-2]) exp_n = '0;
    end
  end

  logic             v1, inan1, sign1, zero1;
  logic [1:0]       rm1;
  logic [MAN_W-1:0] inanf1;
  logic [EXP_W:0]   exp1;
  logic [FW-2:0]    nf1;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      v1     <= 1'b0;
      inan1  <= 1'b0;
      sign1  <= 1'b0;
      zero1  <= 1'b0;
      rm1    <= '0;
      inanf1 <= '0;
      exp1   <= '0;
      nf1    <= '0;
    end else if (e) begin
      v1     <= in_valid;
      inan1  <= n_is_inf_nan;
      sign1  <= n_sign;
      zero1  <= zero_n;
      rm1    <= n_rm;
      inanf1 <= n_inf_nan_frac;
      exp1   <= exp_n;
      nf1    <= nf;
    end
  end

  // ---------------- N2: round and pack ----------------
  logic                 g, rs, lsb, inc, ovf;
  logic [MAN_W:0]       m24;
  logic [MAN_W+1:0]     sum;
  logic [MAN_W-1:0]     man_r;
  logic [EXP_W:0]       exp_r;
  logic [EXP_W+MAN_W-1:0] inf_mag, max_mag;
  logic [EXP_W+MAN_W:0] s_d;
  logic                 ovf_d, inex_d;

  assign inf_mag = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_mag = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_comb begin
    g   = nf1[2];
    rs  = nf1[1] | nf1[0];
    lsb = nf1[3];
    m24 = nf1[FW-2:3];
    case (rm1)
      RM_RNE:  inc = g & (rs | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RUP:  inc = ~sign1 & (g | rs);
      default: inc = sign1 & (g | rs);
    endcase
    sum = {1'b0, m24} + {{(MAN_W+1){1'b0}}, inc};
    if (sum[MAN_W+1]) begin
      man_r = sum[MAN_W:1];
      exp_r = exp1 + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      man_r = sum[MAN_W-1:0];
      // A denormal that rounds up into the hidden bit becomes the smallest normal.
      exp_r = (exp1 == '0 && sum[MAN_W]) ? {{EXP_W{1'b0}}, 1'b1} : exp1;
    end
    ovf = exp_r >= EXP_LIMIT;

    s_d    = {sign1, exp_r[EXP_W-1:0], man_r};
    ovf_d  = 1'b0;
    inex_d = g | rs;
    if (inan1) begin
      s_d    = {sign1, {EXP_W{1'b1}}, inanf1};
      inex_d = 1'b0;
    end else if (zero1) begin
      s_d    = {sign1, {(EXP_W+MAN_W){1'b0}}};
      inex_d = 1'b0;
    end else if (ovf) begin
      ovf_d  = 1'b1;
      inex_d = 1'b1;
      case (rm1)
        RM_RNE:  s_d = {sign1, inf_mag};
        RM_RZ:   s_d = {sign1, max_mag};
        RM_RUP:  s_d = {sign1, sign1 ? max_mag : inf_mag};
        RM_RDN:  s_d = {sign1, sign1 ? inf_mag : max_mag};
        default: s_d = {sign1, inf_mag};
      endcase
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      s         <= '0;
      s_valid   <= 1'b0;
      s_ovf     <= 1'b0;
      s_inexact <= 1'b0;
    end else if (e) begin
      s         <= s_d;
      s_valid   <= v1;
      s_ovf     <= ovf_d;
      s_inexact <= inex_d;
    end
  end

endmodule
